multiword_add_sub_sequencer: RTL

Sequential multi-precision adder/subtractor. It accepts operands as a stream of DATA_WIDTH-bit words, least-significant word first, and feeds each word pair into one combinational ripple-carry adder stage. Between words it holds the carry in a register, so wide operands are processed at one word per cycle. It sits directly upstream of the adder, supplying its A/B/Cin, and it registers the adder's S/CF/OF into a valid/ready result stream with final-word flags.

---
 rtl/adder_seq_pkg.sv | 17 +
 rtl/ripple_carry_adder.sv | 37 +++
 rtl/multiword_add_sub_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package adder_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // The word index needs at least one bit even for single-word operations.
  function automatic int cnt_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational ripple-carry adder with carry-out and optional signed-overflow output.
module ripple_carry_adder #(
  parameter int DATA_WIDTH     = 8,
  parameter bit OVERFLOW_LOGIC = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic [DATA_WIDTH-1:0] o_s,
  output logic                  o_cf,
  output logic                  o_of
);

  logic [DATA_WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  genvar k;
  generate
    for (k = 0; k < DATA_WIDTH; k++) begin : g_bit
      assign o_s[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
      assign w_c[k+1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
    end
  endgenerate

  assign o_cf = w_c[DATA_WIDTH];

  // Signed overflow is the disagreement between the carries into and out of the MSB.
  generate
    if (OVERFLOW_LOGIC) begin : g_of
      assign o_of = w_c[DATA_WIDTH] ^ w_c[DATA_WIDTH-1];
    end else begin : g_no_of
      assign o_of = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multiword_add_sub_sequencer.sv
// Streams multi-word add/subtract operands, LSW first, through one ripple-carry stage.
// Define ZERO_FLAG_EN to add the whole-result zero flag output OUT_ZF.
module multiword_add_sub_sequencer
  import adder_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_COUNT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ABORT,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_A,
  input  logic [DATA_WIDTH-1:0] IN_B,
  input  logic                  IN_OP,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_S,
  output logic                  OUT_LAST,
  output logic                  OUT_CF,
  output logic                  OUT_OF,
`ifdef ZERO_FLAG_EN
  output logic                  OUT_ZF,
`endif
  output logic                  BUSY
);

  localparam int             CW       = cnt_width(WORD_COUNT);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WORD_COUNT - 1);

  state_t                r_state;
  logic [CW-1:0]         r_idx;
  logic                  r_op;
  logic                  r_carry;
  logic                  r_outValid;
  logic [DATA_WIDTH-1:0] r_outS;
  logic                  r_outLast;
  logic                  r_cf;
  logic                  r_of;

  logic                  w_inHs;
  logic                  w_outHs;
  logic                  w_first;
  logic                  w_last;
  logic                  w_op;
  logic                  w_cin;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_s;
  logic                  w_cf;
  logic                  w_of;

  assign IN_READY = !ABORT && (!r_outValid || OUT_READY);
  assign w_inHs   = IN_VALID && IN_READY;
  assign w_outHs  = r_outValid && OUT_READY;
  assign w_first  = (r_idx == '0);
  assign w_last   = (r_idx == LAST_IDX);

  // The first word supplies the operation directly; later words reuse the latched one.
  assign w_op  = w_first ? IN_OP : r_op;
  assign w_cin = w_first ? IN_OP : r_carry;
  assign w_b   = IN_B ^ {DATA_WIDTH{w_op == OP_SUB}};

  ripple_carry_adder #(
    .DATA_WIDTH     (DATA_WIDTH),
    .OVERFLOW_LOGIC (1'b1)
  ) u_adder (
    .i_a   (IN_A),
    .i_b   (w_b),
    .i_cin (w_cin),
    .o_s   (w_s),
    .o_cf  (w_cf),
    .o_of  (w_of)
  );

  // RUN persists until the final result word is consumed, unless a new word arrives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else if (ABORT) begin
      r_state <= IDLE;
    end else if (w_inHs) begin
      r_state <= RUN;
    end else if (w_outHs && r_outLast) begin
      r_state <= IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx      <= '0;
      r_op       <= OP_ADD;
      r_carry    <= 1'b0;
      r_outValid <= 1'b0;
      r_outS     <= '0;
      r_outLast  <= 1'b0;
      r_cf       <= 1'b0;
      r_of       <= 1'b0;
    end else if (ABORT) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_cf       <= 1'b0;
      r_of       <= 1'b0;
    end else if (w_inHs) begin
      r_idx      <= w_last ? '0 : r_idx + CW'(1);
      if (w_first) begin
        r_op <= IN_OP;
      end
      r_carry    <= w_cf;
      r_outValid <= 1'b1;
      r_outS     <= w_s;
      r_outLast  <= w_last;
      r_cf       <= w_last & w_cf;
      r_of       <= w_last & w_of;
    end else if (w_outHs) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_cf       <= 1'b0;
      r_of       <= 1'b0;
    end
  end

`ifdef ZERO_FLAG_EN
  logic r_zacc;
  logic r_zf;
  logic w_zaccNext;

  // The accumulator restarts at the first word so no earlier operation leaks in.
  assign w_zaccNext = (w_first || r_zacc) && (w_s == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_zacc <= 1'b0;
      r_zf   <= 1'b0;
    end else if (ABORT) begin
      r_zacc <= 1'b0;
      r_zf   <= 1'b0;
    end else if (w_inHs) begin
      r_zacc <= w_zaccNext;
      r_zf   <= w_last & w_zaccNext;
    end else if (w_outHs) begin
      r_zf   <= 1'b0;
    end
  end

  assign OUT_ZF = r_zf;
`endif

  assign OUT_VALID = r_outValid;
  assign OUT_S     = r_outS;
  assign OUT_LAST  = r_outLast;
  assign OUT_CF    = r_cf;
  assign OUT_OF    = r_of;
  assign BUSY      = (r_state == RUN);

endmodule
